// File: rtl/pf_insn_queue.sv
// pf_insn_queue: small first-word-fall-through instruction FIFO between the
// single-word prefetch and the decode stage. Each entry carries the
// instruction, its byte PC and a bus-error (illegal) flag. Accepting an
// illegal word halts intake until the next flush, so nothing is queued
// behind the error.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_new_pc,
//   i_clear_cache         either one flushes the queue on the next edge
//   i_valid, i_insn,
//   i_pc, i_illegal       prefetch word; accepted when i_valid && o_stalled_n
//   o_stalled_n           queue can take a word (not full, not halted)
//   o_valid, o_insn,
//   o_pc, o_illegal       head entry toward decode
//   i_stalled_n           decode takes the head when o_valid && i_stalled_n
//   o_fill                current occupancy
module pf_insn_queue #(
  parameter int ADDRESS_WIDTH = 30,
  parameter int DATA_WIDTH    = 32,
  parameter int LGDEPTH       = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_new_pc,
  input  logic                     i_clear_cache,
  input  logic                     i_valid,
  input  logic [DATA_WIDTH-1:0]    i_insn,
  input  logic [ADDRESS_WIDTH+1:0] i_pc,
  input  logic                     i_illegal,
  output logic                     o_stalled_n,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_insn,
  output logic [ADDRESS_WIDTH+1:0] o_pc,
  output logic                     o_illegal,
  input  logic                     i_stalled_n,
  output logic [LGDEPTH:0]         o_fill
);

  localparam int                 DEPTH = 1 << LGDEPTH;
  localparam int                 PCW   = ADDRESS_WIDTH + 2;
  localparam logic [LGDEPTH:0]   FULL  = (LGDEPTH+1)'(DEPTH);

  typedef struct packed {
    logic                  illegal;
    logic [PCW-1:0]        pc;
    logic [DATA_WIDTH-1:0] insn;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [LGDEPTH-1:0]   wr_ptr, rd_ptr;
  logic [LGDEPTH:0]     fill;
  logic                 halted;
  logic                 flush, push, pop;
  entry_t               head;

  assign flush = i_new_pc || i_clear_cache;

  // Ready depends on registers only: a full queue refuses a word even when
  // decode pops in the same cycle, keeping i_stalled_n off the prefetch path.
  assign o_stalled_n = (fill != FULL) && !halted;
  assign o_valid     = (fill != '0);

  assign push = i_valid && o_stalled_n && !flush;
  assign pop  = o_valid && i_stalled_n && !flush;

  assign head      = mem[rd_ptr];
  assign o_insn    = head.insn;
  assign o_pc      = head.pc;
  // Storage is not reset, so qualify the flag to keep it clean after reset.
  assign o_illegal = o_valid && head.illegal;
  assign o_fill    = fill;

  // Storage array: no reset needed, content is only observed when valid.
  always_ff @(posedge i_clk)
    if (push)
      mem[wr_ptr] <= '{illegal: i_illegal, pc: i_pc, insn: i_insn};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      halted <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      halted <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      // Sticky until flush: nothing may enter behind a bus-error word.
      if (push && i_illegal) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pf_insn_queue.sv
// tb_pf_insn_queue: directed, table-driven check of pf_insn_queue with
// hand-computed expectations, plus hand-written reset sequences.
module tb_pf_insn_queue;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_new_pc, i_clear_cache, i_valid, i_illegal, i_stalled_n;
  logic [31:0] i_insn, i_pc;
  logic        o_stalled_n, o_valid, o_illegal;
  logic [31:0] o_insn, o_pc;
  logic [2:0]  o_fill;

  int n_vec = 0;
  int n_bad = 0;

  pf_insn_queue #(.ADDRESS_WIDTH(30), .DATA_WIDTH(32), .LGDEPTH(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_new_pc(i_new_pc),
    .i_clear_cache(i_clear_cache), .i_valid(i_valid), .i_insn(i_insn),
    .i_pc(i_pc), .i_illegal(i_illegal), .o_stalled_n(o_stalled_n),
    .o_valid(o_valid), .o_insn(o_insn), .o_pc(o_pc), .o_illegal(o_illegal),
    .i_stalled_n(i_stalled_n), .o_fill(o_fill)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        np, cc, v;
    logic [31:0] insn, pc;
    logic        ill, ds;
    logic        pre_rdy;   // o_stalled_n expected during the cycle
    int          fill;      // occupancy expected after the edge
    logic [31:0] e_insn, e_pc;
    logic        e_ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic np, cc, v, input logic [31:0] insn, pc,
                              input logic ill, ds, pre_rdy, input int fill,
                              input logic [31:0] e_insn, e_pc, input logic e_ill);
    vec_t r;
    r.np = np; r.cc = cc; r.v = v; r.insn = insn; r.pc = pc; r.ill = ill;
    r.ds = ds; r.pre_rdy = pre_rdy; r.fill = fill;
    r.e_insn = e_insn; r.e_pc = e_pc; r.e_ill = e_ill;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_new_pc = 0; i_clear_cache = 0; i_valid = 0; i_insn = '0; i_pc = '0;
    i_illegal = 0; i_stalled_n = 0;
  endtask

  initial begin
    idle_inputs();
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_fill", 64'(o_fill), 64'd0);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_illegal", 64'(o_illegal), 64'd0);
    i_reset = 1'b0;
    #1;
    check("reset_rdy", 64'(o_stalled_n), 64'd1);

    //           np cc v  insn          pc         il ds pre fill e_insn        e_pc       e_il
    // fill with decode stalled
    vecs.push_back(mk(0,0,1,32'h1000_0001,32'h100,0,0,1,1,32'h1000_0001,32'h100,0));
    vecs.push_back(mk(0,0,1,32'h1000_0002,32'h104,0,0,1,2,32'h1000_0001,32'h100,0));
    vecs.push_back(mk(0,0,1,32'h1000_0003,32'h108,0,0,1,3,32'h1000_0001,32'h100,0));
    vecs.push_back(mk(0,0,1,32'h1000_0004,32'h10C,0,0,1,4,32'h1000_0001,32'h100,0));
    // full with simultaneous pop: offered word refused, then accepted
    vecs.push_back(mk(0,0,1,32'h0000_DEAD,32'h110,0,1,0,3,32'h1000_0002,32'h104,0));
    vecs.push_back(mk(0,0,1,32'h0000_DEAD,32'h110,0,1,1,3,32'h1000_0003,32'h108,0));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,0,1,1,2,32'h1000_0004,32'h10C,0));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,0,1,1,1,32'h0000_DEAD,32'h110,0));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,0,1,1,0,32'h0,32'h0,0));
    // streaming, pointers wrap
    vecs.push_back(mk(0,0,1,32'h2000_0000,32'h200,0,1,1,1,32'h2000_0000,32'h200,0));
    vecs.push_back(mk(0,0,1,32'h2000_0001,32'h204,0,1,1,1,32'h2000_0001,32'h204,0));
    vecs.push_back(mk(0,0,1,32'h2000_0002,32'h208,0,1,1,1,32'h2000_0002,32'h208,0));
    vecs.push_back(mk(0,0,1,32'h2000_0003,32'h20C,0,1,1,1,32'h2000_0003,32'h20C,0));
    vecs.push_back(mk(0,0,1,32'h2000_0004,32'h210,0,1,1,1,32'h2000_0004,32'h210,0));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,0,1,1,0,32'h0,32'h0,0));
    // illegal halt
    vecs.push_back(mk(0,0,1,32'hA,32'h300,0,0,1,1,32'hA,32'h300,0));
    vecs.push_back(mk(0,0,1,32'hB,32'h304,1,0,1,2,32'hA,32'h300,0));
    vecs.push_back(mk(0,0,1,32'hC,32'h308,0,0,0,2,32'hA,32'h300,0));
    vecs.push_back(mk(0,0,1,32'hC,32'h308,0,1,0,1,32'hB,32'h304,1));
    vecs.push_back(mk(0,0,1,32'hC,32'h308,0,0,0,1,32'hB,32'h304,1));
    vecs.push_back(mk(1,0,0,32'h0,32'h0,0,0,0,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,0,0,1,0,32'h0,32'h0,0));
    // flush colliding with push and pop
    vecs.push_back(mk(0,0,1,32'h4000_0000,32'h400,0,0,1,1,32'h4000_0000,32'h400,0));
    vecs.push_back(mk(0,0,1,32'h4000_0001,32'h404,0,0,1,2,32'h4000_0000,32'h400,0));
    vecs.push_back(mk(0,0,1,32'h4000_0002,32'h408,0,0,1,3,32'h4000_0000,32'h400,0));
    vecs.push_back(mk(1,0,1,32'h0000_EEEE,32'h40C,0,1,1,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,0,1,1,0,32'h0,32'h0,0));
    // cache-clear flush, then restart from pointer 0
    vecs.push_back(mk(0,0,1,32'h5000_0000,32'h500,0,0,1,1,32'h5000_0000,32'h500,0));
    vecs.push_back(mk(0,1,0,32'h0,32'h0,0,0,1,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,1,32'h5000_0001,32'h504,0,0,1,1,32'h5000_0001,32'h504,0));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,0,1,1,0,32'h0,32'h0,0));

    foreach (vecs[k]) begin
      i_new_pc = vecs[k].np; i_clear_cache = vecs[k].cc; i_valid = vecs[k].v;
      i_insn = vecs[k].insn; i_pc = vecs[k].pc; i_illegal = vecs[k].ill;
      i_stalled_n = vecs[k].ds;
      #1;
      check($sformatf("v%0d_rdy", k), 64'(o_stalled_n), 64'(vecs[k].pre_rdy));
      @(posedge i_clk);
      #1;
      check($sformatf("v%0d_fill", k), 64'(o_fill), 64'(vecs[k].fill));
      check($sformatf("v%0d_valid", k), 64'(o_valid), 64'(vecs[k].fill != 0));
      if (vecs[k].fill != 0) begin
        check($sformatf("v%0d_insn", k), 64'(o_insn), 64'(vecs[k].e_insn));
        check($sformatf("v%0d_pc", k), 64'(o_pc), 64'(vecs[k].e_pc));
        check($sformatf("v%0d_ill", k), 64'(o_illegal), 64'(vecs[k].e_ill));
      end
    end

    // asynchronous reset with two words queued
    idle_inputs();
    i_valid = 1; i_insn = 32'h6000_0000; i_pc = 32'h600;
    @(posedge i_clk); #1;
    i_insn = 32'h6000_0001; i_pc = 32'h604;
    @(posedge i_clk); #1;
    idle_inputs();
    check("async_pre_fill", 64'(o_fill), 64'd2);
    #2;
    i_reset = 1'b1;
    #1;
    check("async_valid", 64'(o_valid), 64'd0);
    check("async_fill", 64'(o_fill), 64'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    check("async_rdy", 64'(o_stalled_n), 64'd1);
    check("async_valid_after", 64'(o_valid), 64'd0);

    // reset also clears the halt
    i_valid = 1; i_insn = 32'h7; i_pc = 32'h700; i_illegal = 1;
    @(posedge i_clk); #1;
    idle_inputs();
    check("halt_rdy", 64'(o_stalled_n), 64'd0);
    check("halt_ill", 64'(o_illegal), 64'd1);
    #2;
    i_reset = 1'b1;
    #1;
    i_reset = 1'b0;
    #1;
    check("halt_reset_rdy", 64'(o_stalled_n), 64'd1);
    check("halt_reset_ill", 64'(o_illegal), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pf_insn_queue.md
Name: pf_insn_queue

Overview:
- Small instruction FIFO between the single-word prefetch and the CPU decode stage.
- Decouples prefetch bus latency from decode stalls: words fetched while decode is stalled are banked here.
- Flushes on branch (i_new_pc) or cache-clear.
- Carries the bus-error (illegal) flag with each word and blocks further intake after an illegal word.

Parameters:
- ADDRESS_WIDTH, 30, word-address width; PC ports are ADDRESS_WIDTH+2 bits (byte address).
- DATA_WIDTH, 32, instruction width.
- LGDEPTH, 2, log2 of queue depth (DEPTH = 2**LGDEPTH). Legal range 1..5.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous reset, active-high
- i_new_pc  in  1  branch: flush queue
- i_clear_cache  in  1  flush queue
- i_valid  in  1  prefetch word valid
- i_insn  in  DATA_WIDTH  prefetch instruction
- i_pc  in  ADDRESS_WIDTH+2  prefetch instruction byte address
- i_illegal  in  1  prefetch word came from a bus error
- o_stalled_n  out  1  ready to prefetch; word accepted when i_valid && o_stalled_n
- o_valid  out  1  head entry valid toward decode
- o_insn  out  DATA_WIDTH  head instruction
- o_pc  out  ADDRESS_WIDTH+2  head PC
- o_illegal  out  1  head entry is a bus-error word
- i_stalled_n  in  1  decode accepts head when o_valid && i_stalled_n
- o_fill  out  LGDEPTH+1  current occupancy (debug/perf)

Behaviour:
- Clocking: one clock. Asynchronous active-high reset clears wr_ptr, rd_ptr, fill, the sticky "halted" flag, and o_valid/o_illegal. Storage array is not reset. o_insn/o_pc are don't-care while o_valid=0.
- flush = i_new_pc || i_clear_cache.
- push = i_valid && o_stalled_n && !flush.
- pop = o_valid && i_stalled_n && !flush.
- o_stalled_n = (fill != DEPTH) && !halted. This is combinational from registers only; it has no path from i_stalled_n, so a full queue never accepts a word, even with a simultaneous pop.
- o_valid = (fill != 0). o_insn, o_pc and o_illegal are read from the array at rd_ptr (first-word-fall-through).
- Latency: a word pushed at edge N is visible on o_valid after edge N, i.e. one cycle after i_valid.
- Update rules:
  - push only: fill+1, wr_ptr+1.
  - pop only: fill-1, rd_ptr+1.
  - push and pop in the same cycle: fill unchanged, both pointers advance.
- Pointers are LGDEPTH bits and wrap modulo DEPTH. fill is LGDEPTH+1 bits and never exceeds DEPTH or goes below 0.
- Halting: pushing a word with i_illegal=1 sets halted. While halted, o_stalled_n=0, so no later word enters behind the error. Words already queued still drain normally. halted clears only on flush or reset.
- Flush cycle: the next edge sets fill=0, wr_ptr=rd_ptr=0 and halted=0. Any simultaneous i_valid word and any decode accept are discarded. o_valid=0 the cycle after the flush.
- Flush has priority over push and pop; reset has priority over everything.
- Reset mid-operation: all queued words are lost and o_valid drops asynchronously.

Test Plan:
- Fill/drain: hold i_stalled_n=0 and push 4 words (insn 0x1000_0001..4, pc 0x100..0x10C). After 4 pushes, fill=4 and o_stalled_n=0. Raise i_stalled_n: outputs appear in order over 4 cycles, then o_valid=0 and fill=0.
- Streaming: i_valid=1 and i_stalled_n=1 continuously. After the first word, o_valid=1 every cycle, fill stays 1, and each word appears exactly one cycle after its input (pc sequence 0x200, 0x204, …).
- Full with simultaneous pop: at fill=4, raise i_stalled_n with i_valid=1. o_stalled_n stays 0 that cycle, fill becomes 3, and the new word is accepted on the following cycle.
- Illegal halt: push 0xA, then 0xB with i_illegal=1, then offer 0xC. o_stalled_n drops after 0xB and 0xC is not accepted. Outputs are 0xA (illegal=0) then 0xB (illegal=1). Pulse i_new_pc: o_stalled_n returns to 1 on the next cycle.
- Flush with collision: fill=3 while i_new_pc, i_valid and i_stalled_n are all high. The next cycle shows fill=0, o_valid=0, and the offered word is not queued.
- Async reset: assert i_reset between clock edges with fill=2. o_valid and fill go to 0 immediately, and o_stalled_n=1 after release.
